pwm_bank: RTL
=============

# pwm_bank

Multi-channel PWM generator that sits directly downstream of the SPI register bank. It consumes the flat `config_regs` bus, which is eight 8-bit registers written over SPI, and generates `NUM_CH` edge-aligned PWM outputs. All channels share one prescaled period counter. It also returns an 8-bit status word that can be wired back into the register bank's status input.

## Interface
- `NUM_REGS`, 8: number of config registers on `config_regs`. Fixed at 8; the layout below assumes it.
- `WIDTH`, 8: register width. The counter, TOP and DUTY fields are all this width.
- `NUM_CH`, 4: number of PWM channels. Legal range is 1..4.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: asynchronous, active-high reset.
- `ena`  in  1: global enable. When low, all state holds, including outputs.
- `config_regs`  in  NUM_REGS*WIDTH: register file. Register n occupies bits [8n+7:8n].
- `pwm_out`  out  NUM_CH: registered PWM outputs.
- `period_tick`  out  1: registered one-cycle pulse at each period wrap.
- `status_regs`  out  WIDTH: registered status word.

## Operation
Register map:
- reg0 CTRL:
  - bit0 EN
  - bit1 INV (invert all outputs)
  - bits[4:2] PRESC
  - bit5 ONESHOT
  - bits[7:6] ignored
- reg1 TOP: the counter runs 0..TOP.
- reg2..reg(1+NUM_CH): DUTY[ch].
- reg6 CH_EN: bits[NUM_CH-1:0] are the per-channel enables.
- reg7: reserved and ignored.

Shadowing:
- TOP, DUTY[], CH_EN and INV are copied into shadow registers on IDLE→RUN and at every wrap.
- Writes made mid-period take effect only from the next period.
- EN, PRESC and ONESHOT are read live.

Prescaler:
- 7-bit counter `pc`. A tick occurs when `pc == 2^PRESC − 1`; on a tick `pc` returns to 0.
- PRESC=0 gives a tick every cycle.
- Changing PRESC mid-run does not clear `pc`. If `pc` already exceeds the new limit, it counts on to 127 and then wraps to 0.

Period counter `cnt` (WIDTH bits):
- On a tick: if `cnt == TOP_sh`, then `cnt` ← 0 (this is a wrap); otherwise `cnt` ← `cnt` + 1.
- TOP=0 means a wrap on every tick.

Channel output, per channel:
- `raw[ch] = CH_EN_sh[ch] & (cnt < DUTY_sh[ch])`
- In RUN, `pwm_out[ch]` ← `raw[ch] ^ INV_sh`.
- DUTY=0 gives constant inactive. DUTY > TOP_sh gives constant active.
- A disabled channel is constant inactive, i.e. it outputs INV_sh.

State machine (evaluated only when `ena`=1):
- IDLE:
  - `cnt`, `pc`, `pwm_out` and the wrap count are 0.
  - EN=1 → RUN: load shadows, `cnt`=0, `pc`=0, wrap count cleared.
- RUN:
  - EN=0 → IDLE on the next edge.
  - A wrap with ONESHOT=1 → DONE.
  - Otherwise stay in RUN.
- DONE:
  - `pwm_out` = 0 and counters hold at 0.
  - EN=0 → IDLE. EN=1 → stay in DONE.
- In IDLE and DONE, `pwm_out` is forced to 0 regardless of INV.

Status:
- `status_regs[1:0]` = state: IDLE=0, RUN=1, DONE=2.
- `status_regs[2]` = `pwm_out[0]`.
- `status_regs[7:3]` = wrap count, saturating at 31.

## Timing
- Reset values: state=IDLE, `cnt`=0, `pc`=0, all shadows 0, `pwm_out`=0, `period_tick`=0, `status_regs`=0.
- Edge E0 samples EN=1 in IDLE: from E0, state=RUN and `cnt`=0.
- At E1, `pwm_out` takes `raw` computed from `cnt`=0. `pwm_out` always lags `cnt` by exactly one cycle.
- Period = (TOP_sh+1)·2^PRESC cycles. Active time = min(DUTY_sh, TOP_sh+1)·2^PRESC cycles.
- `period_tick` is high for exactly one cycle, starting at the edge where `cnt` goes TOP→0. The same edge loads the shadows and increments the wrap count.
- Disable in RUN: at the edge after EN=0 is sampled, state=IDLE and `pwm_out`=0.
- ONESHOT: the wrap edge moves to DONE and `pwm_out` goes to 0 on that same edge. `period_tick` still pulses.
- `ena`=0 holds every register, including `period_tick`.
- An asynchronous `rst` mid-run forces reset values immediately, with no clock needed.
- Simultaneous shadow load and a config write on the same edge: the shadow takes the pre-edge value of `config_regs`.

## Test plan
- Reset: assert `rst` mid-run with EN=1 and TOP=9 → `pwm_out`=0, `period_tick`=0, `status_regs`=0 immediately. After release, the block starts again from `cnt`=0.
- Basic, with TOP=9, PRESC=0, DUTY0=3, CH_EN=0x1, EN=1:
  - `pwm_out[0]` is high 3 of every 10 cycles.
  - `period_tick` pulses every 10 cycles.
  - `pwm_out[3:1]`=0.
  - `status_regs[7:3]` counts wraps and saturates at 31.
- Prescale, with TOP=3, PRESC=2, DUTY1=2, CH_EN=0x2 → 16-cycle period, `pwm_out[1]` high for 8 cycles.
- Boundary duties, with TOP=9, CH_EN=0xF:
  - DUTY0=0 → constant 0.
  - DUTY1=10 → constant 1.
  - DUTY2=255 → constant 1.
  - TOP=0 with DUTY3=1 → constant 1 and a tick every cycle.
  - Setting INV=1 inverts all four outputs.
- Shadowing: change DUTY0 from 3 to 7 at `cnt`=5 → the current period keeps 3 high cycles; the next period has 7. `period_tick` marks the switch.
- One-shot, with ONESHOT=1, TOP=4, DUTY0=2:
  - Exactly one period is generated, then `status_regs[1:0]`=2 and `pwm_out`=0.
  - EN=0 → IDLE.
  - EN=1 again → a new period starts.
  - Toggling `ena` low mid-period freezes `cnt` and `pwm_out`.

Source files
------------

// File: rtl/pwm_bank_if.sv
// Bundle between the SPI register bank and the PWM bank: enable, the flat config
// register file, the PWM outputs and the status word.
interface pwm_bank_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_CH   = 4
);
    logic                      ena;
    logic [NUM_REGS*WIDTH-1:0] config_regs;
    logic [NUM_CH-1:0]         pwm_out;
    logic                      period_tick;
    logic [WIDTH-1:0]          status_regs;

    modport master (
        output ena,
        output config_regs,
        input  pwm_out,
        input  period_tick,
        input  status_regs
    );

    modport slave (
        input  ena,
        input  config_regs,
        output pwm_out,
        output period_tick,
        output status_regs
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel edge-aligned PWM generator sharing one prescaled period counter.
// TOP/DUTY/CH_EN/INV are shadowed at run start and at every period wrap.
module pwm_bank #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_CH   = 4
) (
    input logic          clk,
    input logic          rst,
    pwm_bank_if.slave    bus
);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

    state_e            r_state, w_state_d;
    logic [WIDTH-1:0]  r_cnt, w_cnt_d;
    logic [6:0]        r_pc, w_pc_d;
    logic [WIDTH-1:0]  r_top_sh;
    logic [WIDTH-1:0]  r_duty_sh [NUM_CH];
    logic [NUM_CH-1:0] r_chen_sh;
    logic              r_inv_sh;
    logic [NUM_CH-1:0] r_pwm, w_pwm_d;
    logic              r_tick, w_tick_d;
    logic [4:0]        r_wraps, w_wraps_d;
    logic              w_load;

    logic              w_en, w_inv, w_oneshot;
    logic [2:0]        w_presc;
    logic [WIDTH-1:0]  w_top;
    logic [NUM_CH-1:0] w_chen;
    logic [7:0]        w_pc_lim;
    logic              w_ptick, w_wrap;
    logic [NUM_CH-1:0] w_raw;
    logic              w_unused_cfg;

    assign w_en         = bus.config_regs[0];
    assign w_inv        = bus.config_regs[1];
    assign w_presc      = bus.config_regs[4:2];
    assign w_oneshot    = bus.config_regs[5];
    assign w_top        = bus.config_regs[1*WIDTH +: WIDTH];
    assign w_chen       = bus.config_regs[6*WIDTH +: NUM_CH];
    assign w_unused_cfg = ^bus.config_regs;

    // Limit is 2^PRESC-1; a pc already past a lowered limit runs on to 127 and wraps.
    assign w_pc_lim = (8'd1 << w_presc) - 8'd1;
    assign w_ptick  = (r_pc == w_pc_lim[6:0]);
    assign w_wrap   = w_ptick && (r_cnt == r_top_sh);

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_raw[ch] = r_chen_sh[ch] & (r_cnt < r_duty_sh[ch]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else if (bus.ena) begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_en) w_state_d = StRun;
            StRun: begin
                if (!w_en)                     w_state_d = StIdle;
                else if (w_wrap && w_oneshot)  w_state_d = StDone;
            end
            StDone:  if (!w_en) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_cnt_d   = r_cnt;
        w_pc_d    = r_pc;
        w_pwm_d   = '0;
        w_tick_d  = 1'b0;
        w_wraps_d = r_wraps;
        w_load    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d   = '0;
                w_pc_d    = '0;
                w_wraps_d = '0;
                w_load    = w_en;
            end
            StRun: begin
                if (!w_en) begin
                    w_cnt_d   = '0;
                    w_pc_d    = '0;
                    w_wraps_d = '0;
                end else begin
                    w_pwm_d = w_raw ^ {NUM_CH{r_inv_sh}};
                    w_pc_d  = w_ptick ? 7'd0 : r_pc + 7'd1;
                    if (w_wrap) begin
                        w_cnt_d  = '0;
                        w_tick_d = 1'b1;
                        w_load   = 1'b1;
                        if (r_wraps != 5'd31) w_wraps_d = r_wraps + 5'd1;
                        if (w_oneshot) w_pwm_d = '0;
                    end else if (w_ptick) begin
                        w_cnt_d = r_cnt + WIDTH'(1);
                    end
                end
            end
            StDone: begin
                w_cnt_d = '0;
                w_pc_d  = '0;
                if (!w_en) w_wraps_d = '0;
            end
            default: begin
                w_cnt_d   = '0;
                w_pc_d    = '0;
                w_wraps_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pc      <= '0;
            r_pwm     <= '0;
            r_tick    <= 1'b0;
            r_wraps   <= '0;
            r_top_sh  <= '0;
            r_chen_sh <= '0;
            r_inv_sh  <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) r_duty_sh[ch] <= '0;
        end else if (bus.ena) begin
            r_cnt   <= w_cnt_d;
            r_pc    <= w_pc_d;
            r_pwm   <= w_pwm_d;
            r_tick  <= w_tick_d;
            r_wraps <= w_wraps_d;
            if (w_load) begin
                r_top_sh  <= w_top;
                r_chen_sh <= w_chen;
                r_inv_sh  <= w_inv;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    r_duty_sh[ch] <= bus.config_regs[(2 + ch) * WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.pwm_out     = r_pwm;
    assign bus.period_tick = r_tick;
    assign bus.status_regs = WIDTH'({r_wraps, r_pwm[0], r_state});

endmodule
